// File: rtl/trap_ctrl_if.sv
// Boundary/CSR bundle for the machine-mode trap sequencer.
// slave = trap_ctrl side, master = pipeline/CSR side.
interface trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
);
  logic               instr_valid_in;
  logic [XLEN-1:0]    pc_in;
  logic [5:0]         exc_flags_in;
  logic               mret_in;
  logic [2:0]         irq_pend_in;
  logic [2:0]         irq_en_in;
  logic               mstatus_mie_in;
  logic [XLEN-1:0]    mtvec_in;
  logic [XLEN-1:0]    mepc_in;

  logic               set_cause_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               i_or_e_out;
  logic               set_epc_out;
  logic [XLEN-1:0]    epc_out;
  logic               mie_clear_out;
  logic               mie_restore_out;
  logic               flush_out;
  logic               stall_out;
  logic               redirect_out;
  logic [XLEN-1:0]    redirect_pc_out;

  modport master (
    output instr_valid_in, pc_in, exc_flags_in, mret_in, irq_pend_in, irq_en_in,
           mstatus_mie_in, mtvec_in, mepc_in,
    input  set_cause_out, cause_out, i_or_e_out, set_epc_out, epc_out, mie_clear_out,
           mie_restore_out, flush_out, stall_out, redirect_out, redirect_pc_out
  );

  modport slave (
    input  instr_valid_in, pc_in, exc_flags_in, mret_in, irq_pend_in, irq_en_in,
           mstatus_mie_in, mtvec_in, mepc_in,
    output set_cause_out, cause_out, i_or_e_out, set_epc_out, epc_out, mie_clear_out,
           mie_restore_out, flush_out, stall_out, redirect_out, redirect_pc_out
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates interrupts/exceptions/MRET at the instruction
// boundary and runs trap entry and return. Optional TRAP_CTRL_VECTORED_EN adds vectored mtvec.
module trap_ctrl #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
) (
  input  logic        clock,
  input  logic        rst_in,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ENTER, REDIR, RET} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t             state_q;
  logic               set_cause_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               i_or_e_q;
  logic               set_epc_q;
  logic [XLEN-1:0]    epc_q;
  logic               mie_clear_q;
  logic               mie_restore_q;
  logic               flush_q;
  logic               stall_q;
  logic               redirect_q;
  logic [XLEN-1:0]    redirect_pc_q;

  logic [2:0]         irq_act;
  logic               trap_hit;
  logic               trap_is_irq;
  logic [CAUSE_W-1:0] trap_cause;
  logic [XLEN-1:0]    vector_pc;

  // Winner selection: enabled interrupts (MEI > MSI > MTI) beat every exception.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    trap_hit    = 1'b1;
    trap_is_irq = 1'b0;
    trap_cause  = '0;
    irq_act     = bus.irq_pend_in & bus.irq_en_in & {3{bus.mstatus_mie_in}};
    if (irq_act[2]) begin
      trap_is_irq = 1'b1;
      trap_cause  = CAUSE_W'(11);
    end else if (irq_act[0]) begin
      trap_is_irq = 1'b1;
      trap_cause  = CAUSE_W'(3);
    end else if (irq_act[1]) begin
      trap_is_irq = 1'b1;
      trap_cause  = CAUSE_W'(7);
    end else if (bus.exc_flags_in[0]) trap_cause = CAUSE_W'(0);
    else if (bus.exc_flags_in[1])     trap_cause = CAUSE_W'(2);
    else if (bus.exc_flags_in[2])     trap_cause = CAUSE_W'(3);
    else if (bus.exc_flags_in[3])     trap_cause = CAUSE_W'(11);
    else if (bus.exc_flags_in[4])     trap_cause = CAUSE_W'(4);
    else if (bus.exc_flags_in[5])     trap_cause = CAUSE_W'(6);
    else                              trap_hit   = 1'b0;
  end

  // Handler address, using the cause/type latched during ENTER.
  always_comb begin
    vector_pc = bus.mtvec_in & ALIGN_MASK;
`ifdef TRAP_CTRL_VECTORED_EN
    if (i_or_e_q && bus.mtvec_in[1:0] == 2'b01)
      vector_pc = (bus.mtvec_in & ALIGN_MASK) + XLEN'({cause_q, 2'b00});
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_in) begin
    // NOTE: every register here is a control/output flop (no storage array), so all of
    // them are reset; this is what makes the outputs drop to 0 asynchronously.
    if (!rst_in) begin
      state_q       <= IDLE;
      set_cause_q   <= 1'b0;
      cause_q       <= '0;
      i_or_e_q      <= 1'b0;
      set_epc_q     <= 1'b0;
      epc_q         <= '0;
      mie_clear_q   <= 1'b0;
      mie_restore_q <= 1'b0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      set_cause_q   <= 1'b0;
      set_epc_q     <= 1'b0;
      mie_clear_q   <= 1'b0;
      mie_restore_q <= 1'b0;
      flush_q       <= 1'b0;
      stall_q       <= 1'b0;
      redirect_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.instr_valid_in) begin
            if (trap_hit) begin
              state_q     <= ENTER;
              set_cause_q <= 1'b1;
              cause_q     <= trap_cause;
              i_or_e_q    <= trap_is_irq;
              set_epc_q   <= 1'b1;
              epc_q       <= bus.pc_in;
              mie_clear_q <= 1'b1;
              flush_q     <= 1'b1;
              stall_q     <= 1'b1;
            end else if (bus.mret_in) begin
              state_q       <= RET;
              mie_restore_q <= 1'b1;
              redirect_q    <= 1'b1;
              flush_q       <= 1'b1;
              redirect_pc_q <= bus.mepc_in & ALIGN_MASK;
            end
          end
        end
        ENTER: begin
          state_q       <= REDIR;
          redirect_q    <= 1'b1;
          stall_q       <= 1'b1;
          redirect_pc_q <= vector_pc;
        end
        REDIR:   state_q <= IDLE;
        RET:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.set_cause_out   = set_cause_q;
  assign bus.cause_out       = cause_q;
  assign bus.i_or_e_out      = i_or_e_q;
  assign bus.set_epc_out     = set_epc_q;
  assign bus.epc_out         = epc_q;
  assign bus.mie_clear_out   = mie_clear_q;
  assign bus.mie_restore_out = mie_restore_q;
  assign bus.flush_out       = flush_q;
  assign bus.stall_out       = stall_q;
  assign bus.redirect_out    = redirect_q;
  assign bus.redirect_pc_out = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a table-driven reference model queues the expected output
// cycles per boundary transaction; a negedge monitor pops and compares whenever a strobe shows.
module tb_trap_ctrl;

  typedef struct packed {
    logic        set_cause;
    logic [3:0]  cause;
    logic        i_or_e;
    logic        set_epc;
    logic [31:0] epc;
    logic        mie_clear;
    logic        mie_restore;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clock;
  logic rst_in;
  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];

  // Values the CSR-facing outputs are expected to hold between strobes.
  logic [3:0]  h_cause;
  logic        h_ie;
  logic [31:0] h_epc;
  logic [31:0] h_rpc;

  // Arbitration tables, highest priority first.
  int irq_bit[3]   = '{2, 0, 1};
  int irq_cause[3] = '{11, 3, 7};
  int exc_bit[6]   = '{0, 1, 2, 3, 4, 5};
  int exc_cause[6] = '{0, 2, 3, 11, 4, 6};

  trap_ctrl_if #(.XLEN(32), .CAUSE_W(4)) bus ();

  trap_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (
    .clock  (clock),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, req);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.set_cause   = bus.set_cause_out;
    o.cause       = bus.cause_out;
    o.i_or_e      = bus.i_or_e_out;
    o.set_epc     = bus.set_epc_out;
    o.epc         = bus.epc_out;
    o.mie_clear   = bus.mie_clear_out;
    o.mie_restore = bus.mie_restore_out;
    o.flush       = bus.flush_out;
    o.stall       = bus.stall_out;
    o.redirect    = bus.redirect_out;
    o.rpc         = bus.redirect_pc_out;
    return o;
  endfunction

  function automatic obs_t mk(input logic sc, input logic se, input logic mc, input logic mr,
                              input logic fl, input logic st, input logic rd);
    obs_t o;
    o.set_cause   = sc;
    o.cause       = h_cause;
    o.i_or_e      = h_ie;
    o.set_epc     = se;
    o.epc         = h_epc;
    o.mie_clear   = mc;
    o.mie_restore = mr;
    o.flush       = fl;
    o.stall       = st;
    o.redirect    = rd;
    o.rpc         = h_rpc;
    return o;
  endfunction

  // Monitor: any active strobe must match the oldest expectation, in its expected cycle.
  obs_t mon_a;
  exp_t mon_e;
  always @(negedge clock) begin
    if (rst_in) begin
      mon_a = sample();
      if (mon_a.set_cause | mon_a.set_epc | mon_a.mie_clear | mon_a.mie_restore |
          mon_a.flush | mon_a.stall | mon_a.redirect) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 128'(mon_a), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
        end else begin
          mon_e = q.pop_front();
          check("strobe_cycle", 128'(cyc), 128'(mon_e.cyc));
          check("outputs", 128'(mon_a), 128'(mon_e.o));
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        check("missing_strobe", 128'(mon_a), 128'(mon_e.o));
      end
    end
  end

  task automatic drive_idle();
    bus.instr_valid_in = 1'b0;
    bus.exc_flags_in   = '0;
    bus.mret_in        = 1'b0;
    bus.irq_pend_in    = '0;
  endtask

  // Garbage presented while the sequencer is busy; it must be ignored.
  task automatic drive_junk();
    bus.instr_valid_in = 1'b1;
    bus.pc_in          = $urandom;
    bus.exc_flags_in   = 6'($urandom);
    bus.mret_in        = 1'($urandom);
    bus.irq_pend_in    = 3'b111;
    bus.irq_en_in      = 3'b111;
    bus.mstatus_mie_in = 1'b1;
  endtask

  // Presents one boundary instruction (called at a negedge with the DUT idle), queues the
  // expected response, and returns once the DUT is back in IDLE.
  task automatic run_txn(input logic valid, input logic [31:0] pc, input logic [5:0] flags,
                         input logic mret, input logic [2:0] pend, input logic [2:0] en,
                         input logic mie, input logic [31:0] mtvec, input logic [31:0] mepc);
    int   c0;
    int   busy;
    int   cause;
    logic is_irq;
    logic hit;
    logic [2:0] act;
    logic [31:0] target;
    bus.instr_valid_in = valid;
    bus.pc_in          = pc;
    bus.exc_flags_in   = flags;
    bus.mret_in        = mret;
    bus.irq_pend_in    = pend;
    bus.irq_en_in      = en;
    bus.mstatus_mie_in = mie;
    bus.mtvec_in       = mtvec;
    bus.mepc_in        = mepc;
    c0     = cyc;
    busy   = 0;
    hit    = 1'b0;
    is_irq = 1'b0;
    cause  = 0;
    act    = mie ? (pend & en) : 3'b000;
    if (valid) begin
      for (int i = 0; i < 3; i++)
        if (!hit && act[irq_bit[i]]) begin
          hit = 1'b1; is_irq = 1'b1; cause = irq_cause[i];
        end
      for (int i = 0; i < 6; i++)
        if (!hit && flags[exc_bit[i]]) begin
          hit = 1'b1; cause = exc_cause[i];
        end
      if (hit) begin
        h_cause = 4'(cause);
        h_ie    = is_irq;
        h_epc   = pc;
        q.push_back('{c0 + 1, mk(1, 1, 1, 0, 1, 1, 0)});
        target = (mtvec / 4) * 4;
`ifdef TRAP_CTRL_VECTORED_EN
        if (is_irq && (mtvec % 4) == 1) target = target + 32'(cause) * 4;
`endif
        h_rpc = target;
        q.push_back('{c0 + 2, mk(0, 0, 0, 0, 0, 1, 1)});
        busy = 2;
      end else if (mret) begin
        h_rpc = (mepc / 4) * 4;
        q.push_back('{c0 + 1, mk(0, 0, 0, 1, 1, 0, 1)});
        busy = 1;
      end
    end
    @(negedge clock);
    repeat (busy) begin
      drive_junk();
      @(negedge clock);
    end
    drive_idle();
  endtask

  task automatic reset_mid_enter();
    bus.instr_valid_in = 1'b1;
    bus.pc_in          = 32'h0000_0400;
    bus.exc_flags_in   = 6'b000010;
    bus.mret_in        = 1'b0;
    bus.irq_pend_in    = '0;
    @(posedge clock);
    #2 rst_in = 1'b0;
    #1;
    h_cause = '0; h_ie = 1'b0; h_epc = '0; h_rpc = '0;
    q.delete();
    check("async_reset_in_enter", 128'(sample()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clock);
    drive_idle();
    repeat (2) @(negedge clock);
    rst_in = 1'b1;
    repeat (4) @(negedge clock);
    check("idle_after_reset", 128'(sample()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    h_cause = '0; h_ie = 1'b0; h_epc = '0; h_rpc = '0;
    rst_in  = 1'b0;
    drive_idle();
    bus.pc_in          = '0;
    bus.irq_en_in      = '0;
    bus.mstatus_mie_in = 1'b0;
    bus.mtvec_in       = '0;
    bus.mepc_in        = '0;
    repeat (3) @(negedge clock);
    check("reset_state", 128'(sample()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
    rst_in = 1'b1;
    @(negedge clock);

    // Illegal instruction, then interrupt beating ecall, then MRET.
    run_txn(1, 32'h100, 6'b000010, 0, 3'b000, 3'b000, 0, 32'h200, 32'h0);
    run_txn(1, 32'h2468, 6'b001000, 0, 3'b110, 3'b111, 1, 32'h200, 32'h0);
    run_txn(1, 32'h500, 6'b000000, 1, 3'b000, 3'b000, 0, 32'h200, 32'h344);
    // Masked interrupt with and without a valid instruction: nothing happens.
    run_txn(1, 32'h600, 6'b000000, 0, 3'b010, 3'b111, 0, 32'h200, 32'h344);
    run_txn(0, 32'h604, 6'b111111, 1, 3'b111, 3'b111, 1, 32'h200, 32'h344);
    check("masked_no_strobe", 128'(sample()), 128'(mk(0, 0, 0, 0, 0, 0, 0)));
    // Exception on an MRET, then interrupt on an MRET.
    run_txn(1, 32'h700, 6'b000100, 1, 3'b000, 3'b000, 1, 32'h203, 32'h344);
    run_txn(1, 32'h704, 6'b000000, 1, 3'b001, 3'b001, 1, 32'h201, 32'h344);
    // Vectored (or direct, in the default build) mtvec with a timer interrupt and an ecall.
    run_txn(1, 32'h800, 6'b000000, 0, 3'b010, 3'b010, 1, 32'h1001, 32'h0);
    run_txn(1, 32'h804, 6'b001000, 0, 3'b000, 3'b000, 1, 32'h1001, 32'h0);

    reset_mid_enter();

    for (int n = 0; n < 300; n++) begin
      logic [5:0] flags;
      case ($urandom_range(0, 3))
        0:       flags = '0;
        1:       flags = 6'(1 << $urandom_range(0, 5));
        2:       flags = 6'($urandom);
        default: flags = '0;
      endcase
      run_txn($urandom_range(0, 7) != 0, $urandom, flags, $urandom_range(0, 3) == 0,
              3'($urandom), 3'($urandom), 1'($urandom), $urandom, $urandom);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 128'(q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
